// File: rtl/stepup_burst_sched.sv
// Read-side scheduler for the 32->64 step-up FIFO: drains the FIFO in
// fixed-length bursts onto a 64-bit valid/ready/last stream, with a
// flush path that lets a partial tail leave as a short burst.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no burst open; start conditions evaluated every cycle
//   ST_BURST | reads issued up to r_len, beats streamed until tlast taken
module stepup_burst_sched #(
  parameter int DW = 64,
  parameter int CW = 32,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [LW-1:0] burst_len,
  input  logic          flush_req,
  output logic          fifo_rden,
  input  logic          fifo_empty,
  input  logic [CW-1:0] fifo_dcnt,
  input  logic [DW-1:0] fifo_dout,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          busy,
  output logic [31:0]   burst_cnt
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  logic          r_state;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_issued;
  logic [LW-1:0] r_sent;
  logic          r_flush_pending;
  logic [31:0]   r_burst_cnt;

  // Two-entry skid; r_skid0 is always the head
  logic          r_inflight;
  logic [1:0]    r_occ;
  logic [DW-1:0] r_skid0;
  logic [DW-1:0] r_skid1;

  logic [LW-1:0] w_len_eff;
  logic [CW-1:0] w_len_eff_wide;
  logic          w_dcnt_short;
  logic          w_full_ok;
  logic          w_flush_ok;
  logic          w_start;
  logic          w_short_start;
  logic [LW-1:0] w_start_len;
  logic          w_pop;
  logic          w_push;
  logic [2:0]    w_fill;
  logic          w_rden;
  logic          w_last;
  logic          w_done;

  assign w_len_eff      = (burst_len == '0) ? LW'(1) : burst_len;
  assign w_len_eff_wide = {{(CW-LW){1'b0}}, w_len_eff};
  assign w_dcnt_short   = (fifo_dcnt < w_len_eff_wide);

  // A full burst always takes priority over a flush-driven one
  assign w_full_ok     = enable && !w_dcnt_short;
  assign w_flush_ok    = r_flush_pending && (fifo_dcnt != '0);
  assign w_start       = (r_state == ST_IDLE) && (w_full_ok || w_flush_ok);
  assign w_short_start = w_start && !w_full_ok && w_dcnt_short;
  assign w_start_len   = w_short_start ? fifo_dcnt[LW-1:0] : w_len_eff;

  assign w_pop  = m_tvalid && m_tready;
  assign w_push = r_inflight;

  // Words the skid will hold once the in-flight read lands, net of this pop;
  // a new read is only safe if that leaves a free slot for it
  assign w_fill = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rden = (r_state == ST_BURST) && !fifo_empty &&
                  (r_issued < r_len) && (w_fill < 3'd2);

  assign w_last = m_tvalid && (r_sent == (r_len - LW'(1)));
  assign w_done = w_pop && w_last;

  assign fifo_rden = w_rden;
  assign m_tvalid  = (r_occ != 2'd0);
  assign m_tdata   = r_skid0;
  assign m_tlast   = w_last;
  assign busy      = (r_state == ST_BURST);
  assign burst_cnt = r_burst_cnt;

  // Burst FSM: start/length capture, issue and beat counters, burst counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_issued    <= '0;
      r_sent      <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state  <= ST_BURST;
            r_len    <= w_start_len;
            r_issued <= '0;
            r_sent   <= '0;
          end
        end
        default: begin
          if (w_rden) r_issued <= r_issued + LW'(1);
          if (w_pop)  r_sent   <= r_sent + LW'(1);
          if (w_done) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= r_burst_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  // Flush request latch; a new request wins over any same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pending <= 1'b0;
    end else if (flush_req) begin
      r_flush_pending <= 1'b1;
    end else if (w_short_start ||
                 ((r_state == ST_IDLE) && (fifo_dcnt == '0))) begin
      r_flush_pending <= 1'b0;
    end
  end

  // Skid buffer: capture read data the cycle after rden, shift on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_skid0    <= '0;
      r_skid1    <= '0;
    end else begin
      r_inflight <= w_rden;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_skid0 <= fifo_dout;
          else               r_skid1 <= fifo_dout;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_skid0 <= r_skid1;
          r_occ   <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_skid0 <= fifo_dout;
          end else begin
            r_skid0 <= r_skid1;
            r_skid1 <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stepup_burst_sched.sv
// Directed bench for stepup_burst_sched with a non-FWFT FIFO model and a
// beat monitor that tracks data order, stall stability and burst lengths.
module tb_stepup_burst_sched;
  localparam int DW = 64;
  localparam int CW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [LW-1:0] burst_len;
  logic          flush_req;
  logic          fifo_rden;
  logic          fifo_empty;
  logic [CW-1:0] fifo_dcnt;
  logic [DW-1:0] fifo_dout = '0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          busy;
  logic [31:0]   burst_cnt;

  logic [DW-1:0] mem [0:63];
  logic [31:0]   wr_ptr  = '0;
  logic [31:0]   rd_ptr  = '0;
  logic [31:0]   mon_ptr = '0;

  int n_checks  = 0;
  int n_errors  = 0;
  int mon_beats = 0;
  int cur_beats = 0;
  int burst_lens[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  stepup_burst_sched #(.DW(DW), .CW(CW), .LW(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .burst_len  (burst_len),
    .flush_req  (flush_req),
    .fifo_rden  (fifo_rden),
    .fifo_empty (fifo_empty),
    .fifo_dcnt  (fifo_dcnt),
    .fifo_dout  (fifo_dout),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .busy       (busy),
    .burst_cnt  (burst_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_dcnt  = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_dcnt == '0);

  // Non-FWFT FIFO read port: data appears the cycle after rden
  always @(posedge clk) begin
    if (fifo_rden) begin
      fifo_dout <= mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 32'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[5:0]] = {16'hC0DE, 16'h0000, wr_ptr};
      wr_ptr = wr_ptr + 32'd1;
    end
  endtask

  task automatic wait_cnt(input logic [31:0] target, input int budget);
    int k = 0;
    while (burst_cnt != target && k < budget) begin
      tick(1);
      k++;
    end
    check("wait_burst_cnt", burst_cnt, target);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k = 0;
    while (mon_beats < target && k < budget) begin
      tick(1);
      k++;
    end
    check("wait_beats", 64'(mon_beats), 64'(target));
  endtask

  function automatic int last_len(input int k);
    if (burst_lens.size() < k) return -1;
    return burst_lens[burst_lens.size() - k];
  endfunction

  // Sampled on the falling edge, away from the active edge
  task automatic mon_step();
    if (!rst_n) begin
      mon_ptr    = rd_ptr;
      cur_beats  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", 64'(m_tvalid), 64'd1);
        check("stall_data_hold", m_tdata, prev_data);
      end
      if (busy) check("skid_occupancy_le2", 64'((rd_ptr - mon_ptr) <= 32'd2), 64'd1);
      if (m_tvalid && m_tready) begin
        check("beat_data_order", m_tdata, mem[mon_ptr[5:0]]);
        mon_ptr = mon_ptr + 32'd1;
        mon_beats++;
        cur_beats++;
        if (m_tlast) begin
          burst_lens.push_back(cur_beats);
          cur_beats = 0;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  endtask

  initial begin
    logic [3:0] pat;
    int b0;
    rst_n     = 1'b0;
    enable    = 1'b0;
    burst_len = 8'd4;
    flush_req = 1'b0;
    m_tready  = 1'b1;
    pat       = 4'b1001;

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    // Reset state
    tick(2);
    check("rst_rden", 64'(fifo_rden), 64'd0);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_tdata", m_tdata, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_burst_cnt", burst_cnt, 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Two full 4-beat bursts out of 10 words; latency and throughput
    push(10);
    enable = 1'b1;
    tick(1);
    check("t1_busy_after_start", 64'(busy), 64'd1);
    check("t1_rden_cycle1", 64'(fifo_rden), 64'd1);
    tick(1);
    check("t1_no_valid_cycle2", 64'(m_tvalid), 64'd0);
    tick(1);
    check("t1_first_valid_cycle3", 64'(m_tvalid), 64'd1);
    tick(3);
    check("t1_tlast_beat4_back_to_back", 64'(m_tlast), 64'd1);
    check("t1_cnt_before_last", burst_cnt, 64'd0);
    tick(1);
    check("t1_cnt_after_burst1", burst_cnt, 64'd1);
    check("t1_idle_between", 64'(busy), 64'd0);
    wait_cnt(32'd2, 60);
    tick(5);
    check("t1_len_burst1", 64'(last_len(2)), 64'd4);
    check("t1_len_burst2", 64'(last_len(1)), 64'd4);
    check("t1_dcnt_left", fifo_dcnt, 64'd2);
    check("t1_idle_short_tail", 64'(busy), 64'd0);

    // Flush drains the 2-word tail as a short burst
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    wait_cnt(32'd3, 60);
    check("t2_flush_len", 64'(last_len(1)), 64'd2);
    check("t2_busy_after", 64'(busy), 64'd0);
    check("t2_dcnt_empty", fifo_dcnt, 64'd0);
    enable = 1'b0;
    push(1);
    tick(10);
    check("t2_pending_cleared_idle", 64'(busy), 64'd0);
    check("t2_pending_cleared_cnt", burst_cnt, 64'd3);
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    wait_cnt(32'd4, 60);
    check("t2_flush_no_enable_len", 64'(last_len(1)), 64'd1);

    // 8-beat burst under 1,0,0,1 backpressure
    burst_len = 8'd8;
    push(16);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    check("t3_started", 64'(busy), 64'd1);
    for (int c = 0; c < 300 && burst_cnt != 32'd5; c++) begin
      m_tready = pat[c[1:0]];
      tick(1);
    end
    m_tready = 1'b1;
    check("t3_burst_done", burst_cnt, 64'd5);
    check("t3_len", 64'(last_len(1)), 64'd8);
    check("t3_dcnt_left", fifo_dcnt, 64'd8);
    enable = 1'b1;
    wait_cnt(32'd6, 60);
    enable = 1'b0;
    check("t3_second_len", 64'(last_len(1)), 64'd8);

    // burst_len = 0 behaves as 1
    burst_len = 8'd0;
    push(3);
    enable = 1'b1;
    wait_cnt(32'd9, 80);
    enable = 1'b0;
    check("t4_len_a", 64'(last_len(3)), 64'd1);
    check("t4_len_b", 64'(last_len(2)), 64'd1);
    check("t4_len_c", 64'(last_len(1)), 64'd1);
    check("t4_dcnt_empty", fifo_dcnt, 64'd0);

    // enable drop and burst_len change mid-burst are ignored until next start
    burst_len = 8'd4;
    push(6);
    b0 = mon_beats;
    enable = 1'b1;
    wait_beats(b0 + 2, 60);
    enable    = 1'b0;
    burst_len = 8'd2;
    wait_cnt(32'd10, 60);
    check("t5_len_kept", 64'(last_len(1)), 64'd4);
    tick(10);
    check("t5_stays_idle", 64'(busy), 64'd0);
    check("t5_cnt", burst_cnt, 64'd10);
    check("t5_dcnt_left", fifo_dcnt, 64'd2);
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    wait_cnt(32'd11, 60);
    check("t5_flush_len", 64'(last_len(1)), 64'd2);

    // Reset during beat 3 of an 8-beat burst
    burst_len = 8'd8;
    push(16);
    b0 = mon_beats;
    enable = 1'b1;
    wait_beats(b0 + 2, 60);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(m_tvalid), 64'd0);
    check("t6_rst_rden", 64'(fifo_rden), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_cnt", burst_cnt, 64'd0);
    check("t6_rst_dcnt", fifo_dcnt, 64'd12);
    tick(1);
    rst_n = 1'b1;
    wait_cnt(32'd1, 80);
    enable = 1'b0;
    check("t6_fresh_len", 64'(last_len(1)), 64'd8);
    check("t6_dcnt_left", fifo_dcnt, 64'd4);
    check("t6_total_bursts", 64'(burst_lens.size()), 64'd12);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stepup_burst_sched.md
Name: stepup_burst_sched

Overview:
- Read-side scheduler for the 32→64-bit step-up FIFO.
- Watches the FIFO word count and drains it in fixed-length bursts onto a 64-bit valid/ready/last stream toward the DMA/accelerator input.
- A flush request lets a partial tail drain as a short burst.
- Owns the FIFO rden; the FIFO write side is untouched.

Parameters:
- DW, 64, FIFO output / stream data width.
- CW, 32, width of the FIFO dcnt input.
- LW, 8, width of the burst-length config and of the internal beat counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  permits starting new bursts; an in-progress burst always completes.
- burst_len  in  LW  beats per burst, sampled only at burst start; 0 is treated as 1.
- flush_req  in  1  single-cycle pulse: drain whatever is left, even if below burst_len.
- fifo_rden  out  1  FIFO read enable.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dcnt  in  CW  count of 64-bit words readable from the FIFO.
- fifo_dout  in  DW  FIFO read data, valid exactly 1 cycle after fifo_rden (non-FWFT).
- m_tdata  out  DW  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  marks the final beat of a burst.
- busy  out  1  high whenever the scheduler is not in IDLE.
- burst_cnt  out  32  count of completed bursts, wraps at 2^32.

Behaviour:
- Reset (async, rst_n=0): state IDLE; fifo_rden=0, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, burst_cnt=0; flush_pending=0; skid buffer emptied; in-flight read discarded.
- Reset clears only this block; FIFO contents are not touched.
- flush_req sets flush_pending.
- flush_pending clears when:
  - a burst starts with len < len_eff, or
  - the scheduler is in IDLE and fifo_dcnt=0.
- len_eff = (burst_len==0) ? 1 : burst_len.
- States:
  - IDLE:
    - enable && dcnt >= len_eff → BURST, len = len_eff.
    - Otherwise flush_pending && dcnt > 0 → BURST, len = min(dcnt, len_eff).
    - Otherwise stay in IDLE.
    - Start is evaluated every cycle; enable is not required for a flush.
  - BURST:
    - Issue reads until `issued == len`.
    - Stream beats; the handshake on the beat with m_tlast → IDLE and burst_cnt+1.
    - A new start may be evaluated on the very next cycle (no dead cycle required).
- Read issue in BURST: fifo_rden=1 iff all of:
  - !fifo_empty
  - issued < len
  - (skid_occupancy + inflight − pop_this_cycle) < 2
- The skid is 2 entries deep. Each returned word is written to the skid tail on the cycle after rden.
- Output:
  - m_tvalid = skid non-empty; m_tdata = skid head.
  - Pop on m_tvalid && m_tready.
  - m_tdata and m_tvalid must hold stable while m_tvalid && !m_tready.
- m_tlast = m_tvalid && (sent == len−1). sent counts beats handshaked in the current burst.
- Latency: with an empty pipeline and m_tready=1:
  - start condition sampled at edge E;
  - fifo_rden high in cycle E+1;
  - first m_tvalid in cycle E+3;
  - then 1 beat/clock sustained for the rest of the burst.
- Backpressure: at most 2 words are buffered. rden stops before the skid would overflow; no beat is ever dropped or duplicated.
- fifo_empty going high mid-burst: rden held low, the scheduler waits in BURST, no timeout.
- enable deasserted mid-burst: the burst finishes normally; no new start occurs.
- flush_req during BURST: latched, acted on in IDLE.
- Simultaneous enable start and flush: the full burst wins if dcnt >= len_eff.
- burst_len change mid-burst: ignored until the next start.
- Reset mid-burst: immediate return to reset values; m_tvalid drops asynchronously.

Test Plan:
- burst_len=4, write 10 words (dcnt 10), enable=1, m_tready=1:
  - two bursts of 4 beats, tlast on beats 4 and 8;
  - dcnt=2 remains; burst_cnt=2;
  - first tvalid 3 cycles after start.
- Then flush_req pulse: one 2-beat burst, tlast on beat 2, burst_cnt=3, flush_pending cleared, busy=0.
- burst_len=8, dcnt 16, m_tready toggling 1,0,0,1 repeating:
  - 8 beats in order (data 0..7 pattern intact);
  - tdata stable during stalls;
  - skid occupancy never exceeds 2; no loss or duplication.
- burst_len=0, dcnt 3, enable=1: three 1-beat bursts, tlast on every beat, burst_cnt=3.
- burst_len=4, mid-burst after beat 2: enable=0, burst_len changed to 2: beats 3–4 still sent, tlast on beat 4, then stays IDLE.
- rst_n low for 1 cycle during beat 3 of an 8-beat burst: tvalid, rden, busy and burst_cnt go to 0 immediately; after release with enable=1 and dcnt >= 8, a fresh burst starts with sent=0.
